// File: rtl/alu_pkg.sv
// Shared opcode encoding for the pipelined MAC ALU and its testbench.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_MUL = 3'b010,
      ALU_MAC = 3'b011,
      ALU_AND = 3'b100,
      ALU_OR  = 3'b101,
      ALU_XOR = 3'b110,
      ALU_CLR = 3'b111
   } alu_op_t;

endpackage

// File: rtl/alu_datapath.sv
// Combinational stage-1 arithmetic/logic for one operand pair; carry and borrow
// come out of one-bit-wider add/subtract.
module alu_datapath #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [WIDTH-1:0]   sum,
   output logic               carry,
   output logic [WIDTH-1:0]   diff,
   output logic               borrow,
   output logic [2*WIDTH-1:0] product,
   output logic [WIDTH-1:0]   and_r,
   output logic [WIDTH-1:0]   or_r,
   output logic [WIDTH-1:0]   xor_r
);

   assign {carry, sum}   = {1'b0, a} + {1'b0, b};
   assign {borrow, diff} = {1'b0, a} - {1'b0, b};
   assign product        = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   assign and_r          = a & b;
   assign or_r           = a | b;
   assign xor_r          = a ^ b;

endmodule

// File: rtl/pipelined_mac_alu.sv
// Two-stage valid/ready ALU lane with accumulator (MAC/CLR).
// Define ALU_SATURATE_EN to clamp results and the accumulator instead of wrapping.
module pipelined_mac_alu
   import alu_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 2*WIDTH+4
) (
   input  logic                 clock_in,
   input  logic                 reset_in,
   input  logic                 enable_in,
   input  logic [2:0]           opcode_in,
   input  logic [WIDTH-1:0]     alu_input1,
   input  logic [WIDTH-1:0]     alu_input2,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [WIDTH-1:0]     alu_output,
   output logic [ACC_WIDTH-1:0] acc_output,
   output logic                 overflow_out,
   output logic                 zero_out,
   output logic                 out_valid,
   input  logic                 out_ready
);

`ifdef ALU_SATURATE_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   logic                 stall;
   logic                 s1_valid;
   alu_op_t              s1_op;
   logic [WIDTH-1:0]     s1_a, s1_b;
   logic [ACC_WIDTH-1:0] acc_q;

   logic [WIDTH-1:0]     sum, diff, and_r, or_r, xor_r;
   logic                 carry, borrow;
   logic [2*WIDTH-1:0]   product;

   logic [ACC_WIDTH:0]   acc_sum;
   logic [ACC_WIDTH-1:0] acc_mac, acc_nxt;
   logic [WIDTH-1:0]     res;
   logic                 ovf;

   assign stall      = !enable_in || (out_valid && !out_ready);
   assign in_ready   = !stall;
   assign acc_output = acc_q;

   alu_datapath #(.WIDTH(WIDTH)) u_datapath (
      .a       (s1_a),
      .b       (s1_b),
      .sum     (sum),
      .carry   (carry),
      .diff    (diff),
      .borrow  (borrow),
      .product (product),
      .and_r   (and_r),
      .or_r    (or_r),
      .xor_r   (xor_r)
   );

   // The extra top bit of acc_sum is the accumulator carry used for saturation.
   assign acc_sum = {1'b0, acc_q} + {{(ACC_WIDTH+1-2*WIDTH){1'b0}}, product};
   assign acc_mac = (SAT_EN && acc_sum[ACC_WIDTH]) ? '1 : acc_sum[ACC_WIDTH-1:0];

   always_comb begin
      res     = '0;
      ovf     = 1'b0;
      acc_nxt = acc_q;
      unique case (s1_op)
         ALU_ADD: begin
            ovf = carry;
            res = (SAT_EN && carry) ? '1 : sum;
         end
         ALU_SUB: begin
            ovf = borrow;
            res = (SAT_EN && borrow) ? '0 : diff;
         end
         ALU_MUL: begin
            ovf = |product[2*WIDTH-1:WIDTH];
            res = (SAT_EN && ovf) ? '1 : product[WIDTH-1:0];
         end
         ALU_MAC: begin
            acc_nxt = acc_mac;
            ovf     = |acc_mac[ACC_WIDTH-1:WIDTH];
            res     = (SAT_EN && ovf) ? '1 : acc_mac[WIDTH-1:0];
         end
         ALU_AND: res = and_r;
         ALU_OR:  res = or_r;
         ALU_XOR: res = xor_r;
         ALU_CLR: begin
            acc_nxt = '0;
            ovf     = |acc_q[ACC_WIDTH-1:WIDTH];
            res     = (SAT_EN && ovf) ? '1 : acc_q[WIDTH-1:0];
         end
         default: res = '0;
      endcase
   end

   // Both stages advance together; the accumulator commits only as an op enters stage 2.
   always_ff @(posedge clock_in) begin
      if (!reset_in) begin
         s1_valid     <= 1'b0;
         s1_op        <= ALU_ADD;
         s1_a         <= '0;
         s1_b         <= '0;
         out_valid    <= 1'b0;
         alu_output   <= '0;
         acc_q        <= '0;
         overflow_out <= 1'b0;
         zero_out     <= 1'b0;
      end else if (!stall) begin
         s1_valid  <= in_valid;
         out_valid <= s1_valid;
         if (in_valid) begin
            s1_op <= alu_op_t'(opcode_in);
            s1_a  <= alu_input1;
            s1_b  <= alu_input2;
         end
         if (s1_valid) begin
            alu_output   <= res;
            acc_q        <= acc_nxt;
            overflow_out <= ovf;
            zero_out     <= (res == '0);
         end
      end
   end

endmodule

// File: tb/tb_pipelined_mac_alu.sv
// Scoreboard bench for pipelined_mac_alu: a behavioural model predicts each accepted op,
// a negedge monitor compares whenever out_valid is high. Honours ALU_SATURATE_EN.
module tb_pipelined_mac_alu;
   import alu_pkg::*;

   localparam int W  = 8;
   localparam int AW = 20;

   typedef struct {
      logic [W-1:0]  res;
      logic [AW-1:0] acc;
      logic          ovf;
      logic          zero;
   } exp_t;

   logic          clk = 0;
   logic          reset_n = 0;
   logic          enable = 1;
   logic [2:0]    opcode = 0;
   logic [W-1:0]  a_in = 0, b_in = 0;
   logic          in_valid = 0;
   logic          in_ready;
   logic [W-1:0]  alu_output;
   logic [AW-1:0] acc_output;
   logic          overflow_out, zero_out, out_valid;
   logic          out_ready = 1;

   exp_t    sb[$];
   longint  model_acc = 0;
   int      checks = 0;
   int      errors = 0;
   bit      rand_done;

   always #5 clk = ~clk;

   pipelined_mac_alu #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
      .clock_in     (clk),
      .reset_in     (reset_n),
      .enable_in    (enable),
      .opcode_in    (opcode),
      .alu_input1   (a_in),
      .alu_input2   (b_in),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .alu_output   (alu_output),
      .acc_output   (acc_output),
      .overflow_out (overflow_out),
      .zero_out     (zero_out),
      .out_valid    (out_valid),
      .out_ready    (out_ready)
   );

   task automatic checkOutput(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: plain integer arithmetic over the op definitions.
   function automatic exp_t model(input logic [2:0] op, input longint a, input longint b);
      exp_t   e;
      longint lim  = 64'd1 << W;
      longint alim = 64'd1 << AW;
      longint r    = 0;
      bit     sat  = 0;
      bit     o    = 0;
`ifdef ALU_SATURATE_EN
      sat = 1;
`endif
      case (op)
         3'd0: begin r = a + b; o = (r >= lim); if (o) r = sat ? lim - 1 : r - lim; end
         3'd1: begin o = (a < b); r = o ? (sat ? 0 : a - b + lim) : a - b; end
         3'd2: begin r = a * b; o = (r >= lim); if (o) r = sat ? lim - 1 : r % lim; end
         3'd3: begin
            model_acc = model_acc + a * b;
            if (model_acc >= alim) model_acc = sat ? alim - 1 : model_acc % alim;
            o = (model_acc >= lim);
            r = (o && sat) ? lim - 1 : model_acc % lim;
         end
         3'd4: r = a & b;
         3'd5: r = a | b;
         3'd6: r = a ^ b;
         default: begin
            o = (model_acc >= lim);
            r = (o && sat) ? lim - 1 : model_acc % lim;
            model_acc = 0;
         end
      endcase
      e.res  = W'(r);
      e.acc  = AW'(model_acc);
      e.ovf  = o;
      e.zero = (r == 0);
      return e;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bit ok = 0;
      bit rdy;
      opcode   = op;
      a_in     = a;
      b_in     = b;
      in_valid = 1;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         if (rdy) begin
            ok = 1;
            sb.push_back(model(op, a, b));
         end
         #1;
      end
      in_valid = 0;
      if (!ok) checkOutput("accept_timeout", 0, 1);
   endtask

   task automatic checkLatency();
      @(negedge clk);
      checkOutput("latency_edge1_out_valid", out_valid, 0);
      @(negedge clk);
      checkOutput("latency_edge2_out_valid", out_valid, 1);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int c = 0;
      while (sb.size() != 0 && c < 500) begin
         @(posedge clk); #1;
         c++;
      end
      checkOutput("drain_queue_empty", sb.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Monitor: compare every presented output with the queue head; pop on transfer-out.
   always @(negedge clk) begin
      if (reset_n) begin
         checkOutput("in_ready", in_ready, enable && !(out_valid && !out_ready));
         if (out_valid) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_output", 1, 0);
            end else begin
               checkOutput("alu_output", alu_output, sb[0].res);
               checkOutput("acc_output", acc_output, sb[0].acc);
               checkOutput("overflow_out", overflow_out, sb[0].ovf);
               checkOutput("zero_out", zero_out, sb[0].zero);
               if (out_ready) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_acc", acc_output, 0);
      checkOutput("reset_alu_output", alu_output, 0);
      reset_n = 1;
      @(posedge clk); #1;

      $display("[TB] directed ADD/SUB/MUL");
      applyStimulus(3'd0, 8'd200, 8'd100);
      checkLatency();
      applyStimulus(3'd0, 8'd10, 8'd15);
      applyStimulus(3'd1, 8'd5, 8'd9);
      applyStimulus(3'd1, 8'd9, 8'd9);
      applyStimulus(3'd2, 8'd16, 8'd16);
      applyStimulus(3'd2, 8'd15, 8'd17);
      applyStimulus(3'd4, 8'hF0, 8'h3C);
      applyStimulus(3'd5, 8'hF0, 8'h0C);
      applyStimulus(3'd6, 8'hAA, 8'hAA);
      drain();

      $display("[TB] MAC chain and CLR");
      applyStimulus(3'd3, 8'd3, 8'd4);
      applyStimulus(3'd3, 8'd5, 8'd6);
      applyStimulus(3'd3, 8'd10, 8'd10);
      applyStimulus(3'd7, 8'd0, 8'd0);
      applyStimulus(3'd3, 8'd2, 8'd2);
      applyStimulus(3'd7, 8'd0, 8'd0);
      drain();

      $display("[TB] backpressure hold");
      out_ready = 0;
      fork
         begin
            for (int i = 0; i < 4; i++) applyStimulus(3'd0, W'(i * 7), W'(i + 1));
         end
         begin
            repeat (5) @(posedge clk);
            #2 out_ready = 1;
         end
      join
      drain();

      $display("[TB] enable freeze");
      enable = 0;
      @(negedge clk);
      checkOutput("disabled_in_ready", in_ready, 0);
      @(posedge clk); #1;
      enable = 1;

      $display("[TB] reset with both stages valid");
      out_ready = 0;
      applyStimulus(3'd0, 8'd1, 8'd2);
      applyStimulus(3'd3, 8'd9, 8'd9);
      reset_n = 0;
      @(posedge clk); #1;
      reset_n = 1;
      sb.delete();
      model_acc = 0;
      @(negedge clk);
      checkOutput("post_reset_out_valid", out_valid, 0);
      checkOutput("post_reset_acc", acc_output, 0);
      checkOutput("post_reset_alu_output", alu_output, 0);
      checkOutput("post_reset_in_ready", in_ready, 1);
      out_ready = 1;
      @(posedge clk); #1;
      applyStimulus(3'd0, 8'd1, 8'd1);
      checkLatency();
      drain();

      $display("[TB] randomized traffic");
      rand_done = 0;
      fork
         begin
            for (int i = 0; i < 300; i++)
               applyStimulus(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #2 out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
